// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit and alu_seq.
//
//   master (control unit): drives start, op, a, b; observes the results.
//   slave  (alu_seq)     : samples start, op, a, b; drives result, result_hi,
//                          zero, overflow, cout, illegal, busy, done.
//
// WIDTH must match the WIDTH of the alu_seq instance it is connected to.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;
  logic             cout;
  logic             illegal;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, result_hi, zero, overflow, cout, illegal, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, result_hi, zero, overflow, cout, illegal, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with an iterative shift-add multiplier.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears all state and outputs
//   bus   - alu_seq_if.slave:
//             start/op/a/b     request, sampled only while not busy
//             result           registered result (low product half for MUL)
//             result_hi        high product half for MUL, 0 otherwise
//             zero             result == 0
//             overflow, cout   signed overflow / carry out, ADD and SUB only
//             illegal          captured op code is not in the op table
//             busy             multiplier running, new starts are dropped
//             done             one-cycle pulse, outputs valid
//
// Non-MUL ops complete in the cycle after start. MUL keeps busy high for
// WIDTH cycles and pulses done in the following cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg,     state_next;
  logic [WIDTH-1:0]   result_reg,    result_next;
  logic [WIDTH-1:0]   result_hi_reg, result_hi_next;
  logic               zero_reg,      zero_next;
  logic               overflow_reg,  overflow_next;
  logic               cout_reg,      cout_next;
  logic               illegal_reg,   illegal_next;
  logic [WIDTH-1:0]   mcand_reg,     mcand_next;   // multiplicand (a)
  logic [WIDTH-1:0]   acc_hi_reg,    acc_hi_next;  // upper accumulator half
  logic [WIDTH-1:0]   acc_lo_reg,    acc_lo_next;  // multiplier, shifted out as product bits shift in
  logic [CNT_W-1:0]   cnt_reg,       cnt_next;

  // Single-cycle datapath. SLT shares the subtractor: a + ~b + 1.
  logic             use_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             less;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_cout;
  logic             alu_ill;

  always_comb begin
    use_sub  = (bus.op == OP_SUB) || (bus.op == OP_SLT);
    b_eff    = use_sub ? ~bus.b : bus.b;
    sum_full = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
    sum      = sum_full[WIDTH-1:0];
    add_ovf  = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    // The raw sign of a-b is wrong whenever the subtraction overflows.
    less     = sum[WIDTH-1] ^ add_ovf;

    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    alu_ill  = 1'b0;
    case (bus.op)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      OP_ADD, OP_SUB: begin
        alu_res  = sum;
        alu_ovf  = add_ovf;
        alu_cout = sum_full[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, less};
      default: alu_ill = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift {carry, acc_hi, acc_lo} right by one.
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] acc_hi_step;
  logic [WIDTH-1:0] acc_lo_step;

  always_comb begin
    partial     = acc_lo_reg[0] ? ({1'b0, acc_hi_reg} + {1'b0, mcand_reg})
                                : {1'b0, acc_hi_reg};
    acc_hi_step = partial[WIDTH:1];
    acc_lo_step = {partial[0], acc_lo_reg[WIDTH-1:1]};
  end

  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    result_hi_next = result_hi_reg;
    zero_next      = zero_reg;
    overflow_next  = overflow_reg;
    cout_next      = cout_reg;
    illegal_next   = illegal_reg;
    mcand_next     = mcand_reg;
    acc_hi_next    = acc_hi_reg;
    acc_lo_next    = acc_lo_reg;
    cnt_next       = cnt_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            // Previous outputs stay visible while the multiplier runs.
            mcand_next  = bus.a;
            acc_lo_next = bus.b;
            acc_hi_next = '0;
            cnt_next    = CNT_W'(WIDTH);
            state_next  = MUL;
          end else begin
            result_next    = alu_res;
            result_hi_next = '0;
            zero_next      = (alu_res == '0);
            overflow_next  = alu_ovf;
            cout_next      = alu_cout;
            illegal_next   = alu_ill;
            state_next     = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end

      MUL: begin
        acc_hi_next = acc_hi_step;
        acc_lo_next = acc_lo_step;
        cnt_next    = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          result_next    = acc_lo_step;
          result_hi_next = acc_hi_step;
          zero_next      = (acc_lo_step == '0);
          overflow_next  = 1'b0;
          cout_next      = 1'b0;
          illegal_next   = 1'b0;
          state_next     = DONE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      cout_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      mcand_reg     <= '0;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      result_hi_reg <= result_hi_next;
      zero_reg      <= zero_next;
      overflow_reg  <= overflow_next;
      cout_reg      <= cout_next;
      illegal_reg   <= illegal_next;
      mcand_reg     <= mcand_next;
      acc_hi_reg    <= acc_hi_next;
      acc_lo_reg    <= acc_lo_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign bus.result    = result_reg;
  assign bus.result_hi = result_hi_reg;
  assign bus.zero      = zero_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.cout      = cout_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.busy      = (state_reg == MUL);
  assign bus.done      = (state_reg == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH = 32).
// Hand-computed vector table applied back-to-back, directed multi-cycle
// sequences (MUL with dropped starts, reset abort), and random operations
// checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        c;
    logic        ill;
  } vec_t;

  int checks = 0;
  int passed = 0;

  localparam longint SMAX = (longint'(1) <<< 31) - 1;
  localparam longint SMIN = -(longint'(1) <<< 31);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic on the op table.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    vec_t        e;
    longint      sa, sb, sr;
    logic [63:0] p;
    logic [32:0] s;
    e.op = op; e.a = a; e.b = b;
    e.res = '0; e.hi = '0; e.o = 1'b0; e.c = 1'b0; e.ill = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c   = s[32];
        sr    = sa + sb;
        e.o   = (sr > SMAX) || (sr < SMIN);
      end
      4'b0110: begin
        e.res = a - b;
        e.c   = (a >= b);
        sr    = sa - sb;
        e.o   = (sr > SMAX) || (sr < SMIN);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin
        p     = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_out(input string tag, input vec_t e);
    check({tag, " result"},    64'(bus.result),    64'(e.res));
    check({tag, " result_hi"}, 64'(bus.result_hi), 64'(e.hi));
    check({tag, " zero"},      64'(bus.zero),      64'(e.z));
    check({tag, " overflow"},  64'(bus.overflow),  64'(e.o));
    check({tag, " cout"},      64'(bus.cout),      64'(e.c));
    check({tag, " illegal"},   64'(bus.illegal),   64'(e.ill));
  endtask

  // Issue one op, wait (bounded) for completion, check, then check the hold cycle.
  // With inject set, start is re-asserted with an ADD on every busy cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input string tag);
    vec_t e;
    int   busy_cnt;
    int   guard;
    e = model(op, a, b);
    busy_cnt = 0;
    guard = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && guard < 100) begin
      busy_cnt++;
      guard++;
      if (inject) begin
        bus.start = 1'b1; bus.op = 4'b0010; bus.a = $urandom; bus.b = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " busy cycles"}, 64'(busy_cnt), (op == 4'b1000) ? 64'd32 : 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check_out(tag, e);
    $display("%s op=%b a=%h b=%h -> result=%h hi=%h z=%0d o=%0d c=%0d ill=%0d busy_cycles=%0d",
             tag, op, a, b, bus.result, bus.result_hi, bus.zero, bus.overflow,
             bus.cout, bus.illegal, busy_cnt);
    @(negedge clk);
    check({tag, " done drop"}, 64'(bus.done), 64'd0);
    check({tag, " hold"}, 64'(bus.result), 64'(e.res));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[14];
  logic [3:0] legal_ops[8];

  initial begin
    int done_cnt;

    tbl[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0101, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0011, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};

    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1000};

    // Reset, with a start request in the same cycles: reset must win.
    reset = 1'b1;
    bus.start = 1'b1; bus.op = 4'b0010; bus.a = 32'd1; bus.b = 32'd1;
    repeat (3) @(negedge clk);
    check("reset result",    64'(bus.result),    64'd0);
    check("reset result_hi", 64'(bus.result_hi), 64'd0);
    check("reset zero",      64'(bus.zero),      64'd0);
    check("reset overflow",  64'(bus.overflow),  64'd0);
    check("reset cout",      64'(bus.cout),      64'd0);
    check("reset illegal",   64'(bus.illegal),   64'd0);
    check("reset busy",      64'(bus.busy),      64'd0);
    check("reset done",      64'(bus.done),      64'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    $display("reset applied with start held high");

    // Table vectors, issued back-to-back: each start lands in the previous done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = tbl[0].op; bus.a = tbl[0].a; bus.b = tbl[0].b;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d done", i), 64'(bus.done), 64'd1);
      check($sformatf("vec%0d busy", i), 64'(bus.busy), 64'd0);
      check_out($sformatf("vec%0d", i), tbl[i]);
      $display("vec%0d op=%b a=%h b=%h -> result=%h z=%0d o=%0d c=%0d ill=%0d",
               i, tbl[i].op, tbl[i].a, tbl[i].b, bus.result, bus.zero,
               bus.overflow, bus.cout, bus.illegal);
      if (i + 1 < 14) begin
        bus.op = tbl[i+1].op; bus.a = tbl[i+1].a; bus.b = tbl[i+1].b;
      end else begin
        bus.start = 1'b0;
      end
    end

    // Illegal op followed by OR in its done cycle.
    run_op(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b0, "pre_or");
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'b0101; bus.a = 32'h1; bus.b = 32'h2;
    @(negedge clk);
    check("ill done",    64'(bus.done),    64'd1);
    check("ill illegal", 64'(bus.illegal), 64'd1);
    check("ill result",  64'(bus.result),  64'd0);
    check("ill zero",    64'(bus.zero),    64'd1);
    bus.op = 4'b0001; bus.a = 32'h0000_0A00; bus.b = 32'h0000_000B;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b or done",    64'(bus.done),    64'd1);
    check("b2b or illegal", 64'(bus.illegal), 64'd0);
    check("b2b or result",  64'(bus.result),  64'h0000_0A0B);
    $display("illegal op then OR back-to-back -> result=%h ill=%0d", bus.result, bus.illegal);

    // MUL of all-ones operands with an ADD start pulsed on every busy cycle.
    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "mul_ones");
    check("mul_ones lo", 64'(bus.result),    64'h0000_0001);
    check("mul_ones hi", 64'(bus.result_hi), 64'hFFFF_FFFE);

    // Reset on the 10th busy cycle of a MUL aborts it with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'b1000; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy before reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy",   64'(bus.busy),      64'd0);
    check("abort done",   64'(bus.done),      64'd0);
    check("abort result", 64'(bus.result),    64'd0);
    check("abort hi",     64'(bus.result_hi), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    $display("MUL aborted by reset, done pulses afterwards=%0d", done_cnt);
    run_op(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, "post_abort_and");

    // Random operations against the reference model.
    for (int i = 0; i < 120; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
      else op = legal_ops[$urandom_range(0, 7)];
      run_op(op, pick_val(), pick_val(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
